pic_host_sequencer: RTL and testbench

CPU-side controller that owns the bus to the PIC_8259A.
- Programs the PIC at start-up by issuing the ICW1/ICW2/ICW4/OCW1 write sequence.
- Answers INT with the two-pulse INTA acknowledge, captures the vector byte and hands it to a consumer over valid/ready.
- Issues specific or non-specific EOI writes on request.
- Sits between the system processor model and the PIC_8259A instance. It is the only master of chip_select, read_enable, write_enable, A0, the data bus and INTA.

---
 rtl/pic_host_pkg.sv | 43 ++++
 rtl/pic_bus_cycle.sv | 80 ++++++++
 rtl/pic_host_sequencer.sv | 163 ++++++++++++++++
 tb/tb_pic_host_sequencer.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_host_pkg.sv
// Shared types and constants for the PIC 8259A host sequencer.
// The status-read states are only reachable when PIC_STATUS_READ_EN is defined.
package pic_host_pkg;

    typedef enum logic [3:0] {
        IDLE,
        INIT_W1,
        INIT_W2,
        INIT_W4,
        INIT_M,
        READY,
        ACK1,
        ACK_GAP,
        ACK2,
        HOLD_VEC,
        EOI_W,
        RD_OCW3,
        RD_READ
    } state_t;

    typedef enum logic [2:0] {
        PH_IDLE,
        PH_SETUP,
        PH_STROBE,
        PH_HOLD,
        PH_GAP
    } phase_t;

    localparam logic [7:0] OCW3_READ_IRR = 8'h0A;
    localparam logic [7:0] OCW3_READ_ISR = 8'h0B;
    localparam logic [7:0] NS_EOI        = 8'h20;
    localparam logic [4:0] SEOI_PREFIX   = 5'b01100;

    localparam logic [1:0] RD_SEL_IRR  = 2'd0;
    localparam logic [1:0] RD_SEL_ISR  = 2'd1;
    localparam logic [1:0] RD_SEL_IMR  = 2'd2;
    localparam logic [1:0] RD_SEL_RSVD = 2'd3;

    function automatic logic [7:0] eoi_byte(input logic specific, input logic [2:0] level);
        return specific ? {SEOI_PREFIX, level} : NS_EOI;
    endfunction

endpackage

// File: rtl/pic_bus_cycle.sv
// One PIC bus cycle: setup, STROBE_CYCLES strobe, hold (writes only), idle.
// done is high during the idle cycle; a new go is accepted in that same cycle.
module pic_bus_cycle
    import pic_host_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       go,
    input  logic       is_read,
    input  logic       addr,
    input  logic [7:0] wdata,
    output logic       done,
    output logic [7:0] rdata,
    input  logic [7:0] data_in,
    output logic       cs_n,
    output logic       re_n,
    output logic       we_n,
    output logic       a0,
    output logic [7:0] dout,
    output logic       oe
);

    localparam logic [7:0] LAST = 8'(STROBE_CYCLES - 1);

    phase_t     phase;
    logic       rd_q;
    logic [7:0] cnt;

    // Phase sequencer; address and data are latched when the cycle is launched.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase <= PH_IDLE;
            rd_q  <= 1'b0;
            a0    <= 1'b0;
            dout  <= '0;
            rdata <= '0;
            cnt   <= '0;
        end else begin
            case (phase)
                PH_IDLE, PH_GAP: begin
                    if (go) begin
                        phase <= PH_SETUP;
                        rd_q  <= is_read;
                        a0    <= addr;
                        dout  <= is_read ? '0 : wdata;
                    end else begin
                        phase <= PH_IDLE;
                    end
                end
                PH_SETUP: begin
                    phase <= PH_STROBE;
                    cnt   <= '0;
                end
                PH_STROBE: begin
                    if (cnt == LAST) begin
                        if (rd_q) begin
                            rdata <= data_in;
                            phase <= PH_GAP;
                        end else begin
                            phase <= PH_HOLD;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                PH_HOLD: phase <= PH_GAP;
                default: phase <= PH_IDLE;
            endcase
        end
    end

    assign cs_n = (phase == PH_IDLE) || (phase == PH_GAP);
    assign we_n = !((phase == PH_STROBE) && !rd_q);
    assign re_n = !((phase == PH_STROBE) && rd_q);
    assign oe   = !rd_q && ((phase == PH_SETUP) || (phase == PH_STROBE) || (phase == PH_HOLD));
    assign done = (phase == PH_GAP);

endmodule

// File: rtl/pic_host_sequencer.sv
// Host-side master for a PIC 8259A: init sequence, INTA acknowledge, EOI writes.
// Optional status reads (IRR/ISR/IMR) are built when PIC_STATUS_READ_EN is defined.
module pic_host_sequencer
    import pic_host_pkg::*;
#(
    parameter logic [7:0]  ICW1_VAL      = 8'h1F,
    parameter logic [7:0]  ICW2_VAL      = 8'hA8,
    parameter logic [7:0]  ICW4_VAL      = 8'h01,
    parameter logic [7:0]  OCW1_VAL      = 8'h00,
    parameter int unsigned STROBE_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start_init,
    output logic       init_done,
    output logic       busy,
    output logic       chip_select,
    output logic       read_enable,
    output logic       write_enable,
    output logic       A0,
    output logic [7:0] data_out,
    output logic       data_oe,
    input  logic [7:0] data_in,
    input  logic       INT,
    output logic       INTA,
    output logic [7:0] vector,
    output logic       vector_valid,
    input  logic       vector_ready,
    input  logic       eoi_req,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    output logic       eoi_ack
`ifdef PIC_STATUS_READ_EN
   ,input  logic       rd_req,
    input  logic [1:0] rd_sel,
    output logic [7:0] rd_data,
    output logic       rd_valid
`endif
);

    localparam logic [7:0] LAST = 8'(STROBE_CYCLES - 1);

    state_t     state;
    state_t     next;
    logic       int_s1;
    logic       int_s2;
    logic [7:0] cnt;
    logic       go;
    logic       is_read;
    logic       addr;
    logic [7:0] wdata;
    logic       done;
    logic [7:0] rdata;

    pic_bus_cycle #(.STROBE_CYCLES(STROBE_CYCLES)) u_bus (
        .clock   (clock),
        .reset_n (reset_n),
        .go      (go),
        .is_read (is_read),
        .addr    (addr),
        .wdata   (wdata),
        .done    (done),
        .rdata   (rdata),
        .data_in (data_in),
        .cs_n    (chip_select),
        .re_n    (read_enable),
        .we_n    (write_enable),
        .a0      (A0),
        .dout    (data_out),
        .oe      (data_oe)
    );

    // Two-flop synchroniser for the asynchronous INT line.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            int_s1 <= 1'b0;
            int_s2 <= 1'b0;
        end else begin
            int_s1 <= INT;
            int_s2 <= int_s1;
        end
    end

    // State register, per-state cycle counter and vector capture at the end of ACK2.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            vector <= '0;
        end else begin
            state <= next;
            cnt   <= (next != state) ? '0 : cnt + 8'd1;
            if ((state == ACK2) && (cnt == LAST)) begin
                vector <= data_in;
            end
        end
    end

    // Next state; a bus cycle is launched (go) in the cycle its state is entered.
    always_comb begin
        next    = state;
        go      = 1'b0;
        is_read = 1'b0;
        addr    = 1'b0;
        wdata   = '0;
        case (state)
            IDLE: begin
                if (start_init) begin
                    next = INIT_W1;  go = 1'b1;  addr = 1'b0;  wdata = ICW1_VAL;
                end
            end
            INIT_W1: if (done) begin next = INIT_W2; go = 1'b1; addr = 1'b1; wdata = ICW2_VAL; end
            INIT_W2: if (done) begin next = INIT_W4; go = 1'b1; addr = 1'b1; wdata = ICW4_VAL; end
            INIT_W4: if (done) begin next = INIT_M;  go = 1'b1; addr = 1'b1; wdata = OCW1_VAL; end
            INIT_M:  if (done) next = READY;
            READY: begin
                if (start_init) begin
                    next = INIT_W1;  go = 1'b1;  addr = 1'b0;  wdata = ICW1_VAL;
                end else if (eoi_req) begin
                    next = EOI_W;  go = 1'b1;  addr = 1'b0;  wdata = eoi_byte(eoi_specific, eoi_level);
`ifdef PIC_STATUS_READ_EN
                end else if (rd_req) begin
                    go = 1'b1;
                    if ((rd_sel == RD_SEL_IRR) || (rd_sel == RD_SEL_ISR)) begin
                        next  = RD_OCW3;
                        addr  = 1'b0;
                        wdata = (rd_sel == RD_SEL_ISR) ? OCW3_READ_ISR : OCW3_READ_IRR;
                    end else begin
                        next    = RD_READ;
                        is_read = 1'b1;
                        addr    = 1'b1;
                    end
`endif
                end else if (int_s2) begin
                    next = ACK1;
                end
            end
            EOI_W:    if (done) next = READY;
            ACK1:     if (cnt == LAST) next = ACK_GAP;
            ACK_GAP:  next = ACK2;
            ACK2:     if (cnt == LAST) next = HOLD_VEC;
            HOLD_VEC: if (vector_ready) next = READY;
`ifdef PIC_STATUS_READ_EN
            RD_OCW3:  if (done) begin next = RD_READ; go = 1'b1; is_read = 1'b1; addr = 1'b0; end
            RD_READ:  if (done) next = READY;
`endif
            default:  next = IDLE;
        endcase
    end

    assign busy         = (state != IDLE) && (state != READY);
    assign init_done    = !((state == IDLE) || (state == INIT_W1) || (state == INIT_W2) ||
                            (state == INIT_W4) || (state == INIT_M));
    assign INTA         = !((state == ACK1) || (state == ACK2));
    assign vector_valid = (state == HOLD_VEC);
    assign eoi_ack      = (state == EOI_W) && done;

`ifdef PIC_STATUS_READ_EN
    assign rd_data  = rdata;
    assign rd_valid = (state == RD_READ) && done;
`endif

endmodule

// File: tb/tb_pic_host_sequencer.sv
// Randomised self-checking bench for pic_host_sequencer (PIC_STATUS_READ_EN optional).
module tb_pic_host_sequencer;

    localparam int SC = 2;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start_init;
    logic       init_done;
    logic       busy;
    logic       chip_select;
    logic       read_enable;
    logic       write_enable;
    logic       A0;
    logic [7:0] data_out;
    logic       data_oe;
    logic [7:0] data_in;
    logic       INT;
    logic       INTA;
    logic [7:0] vector;
    logic       vector_valid;
    logic       vector_ready;
    logic       eoi_req;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic       eoi_ack;
`ifdef PIC_STATUS_READ_EN
    logic       rd_req;
    logic [1:0] rd_sel;
    logic [7:0] rd_data;
    logic       rd_valid;
`endif

    // PIC model state
    logic [7:0] pic_vec  = 8'h00;
    logic [7:0] pic_irr  = 8'h00;
    logic [7:0] pic_isr  = 8'h00;
    logic [7:0] pic_imr  = 8'h00;
    logic [7:0] ocw3_last = 8'h0A;

    int total = 0;
    int bad   = 0;

    pic_host_sequencer dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start_init   (start_init),
        .init_done    (init_done),
        .busy         (busy),
        .chip_select  (chip_select),
        .read_enable  (read_enable),
        .write_enable (write_enable),
        .A0           (A0),
        .data_out     (data_out),
        .data_oe      (data_oe),
        .data_in      (data_in),
        .INT          (INT),
        .INTA         (INTA),
        .vector       (vector),
        .vector_valid (vector_valid),
        .vector_ready (vector_ready),
        .eoi_req      (eoi_req),
        .eoi_specific (eoi_specific),
        .eoi_level    (eoi_level),
        .eoi_ack      (eoi_ack)
`ifdef PIC_STATUS_READ_EN
       ,.rd_req       (rd_req),
        .rd_sel       (rd_sel),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid)
`endif
    );

    always #5 clock = ~clock;

    assign data_in = !INTA ? pic_vec :
                     !read_enable ? (A0 ? pic_imr : ((ocw3_last == 8'h0B) ? pic_isr : pic_irr)) :
                     8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bus and INTA monitor: one record per chip-select window and per INTA pulse.
    typedef struct { bit rd; bit a0; logic [7:0] d; int strobe; int csw; int oe; int seq; } bus_t;
    typedef struct { int w; int gap; int seq; } pulse_t;
    bus_t   bq[$];
    pulse_t pq[$];
    int     seq = 0;

    initial begin
        bus_t   cur;
        pulse_t p;
        int cs_w = 0, st_w = 0, oe_w = 0, ia_w = 0, ia_gap = 0, ia_start = 0;
        cur = '{0, 0, 8'h00, 0, 0, 0, 0};
        forever begin
            @(negedge clock);
            if (reset_n !== 1'b1) begin
                cs_w = 0; st_w = 0; oe_w = 0; ia_w = 0; ia_gap = 0;
            end else begin
                check("cs_inta_excl", 32'(!chip_select && !INTA), 0);
                check("oe_excl", 32'(data_oe && (!read_enable || !INTA)), 0);
                if (!chip_select) begin
                    cs_w++;
                    cur.a0 = A0;
                    if (data_oe) oe_w++;
                    if (!write_enable) begin st_w++; cur.rd = 1'b0; cur.d = data_out; end
                    if (!read_enable)  begin st_w++; cur.rd = 1'b1; cur.d = data_in;  end
                end else if (cs_w != 0) begin
                    cur.strobe = st_w; cur.csw = cs_w; cur.oe = oe_w; cur.seq = seq++;
                    bq.push_back(cur);
                    if (!cur.rd && !cur.a0 && (cur.d == 8'h0A || cur.d == 8'h0B)) ocw3_last = cur.d;
                    cs_w = 0; st_w = 0; oe_w = 0;
                end
                if (!INTA) begin
                    if (ia_w == 0) ia_start = ia_gap;
                    ia_w++;
                    ia_gap = 0;
                end else begin
                    if (ia_w != 0) begin
                        p.w = ia_w; p.gap = ia_start; p.seq = seq++;
                        pq.push_back(p);
                        ia_w = 0;
                    end
                    ia_gap++;
                end
            end
        end
    end

    task automatic expect_bus(input string tag, input bit rd, input bit a0, input logic [7:0] d);
        bus_t r;
        check({tag, "_present"}, 32'(bq.size() != 0), 1);
        if (bq.size() != 0) begin
            r = bq.pop_front();
            check({tag, "_kind"},   32'(r.rd), 32'(rd));
            check({tag, "_a0"},     32'(r.a0), 32'(a0));
            check({tag, "_data"},   32'(r.d),  32'(d));
            check({tag, "_strobe"}, r.strobe, SC);
            check({tag, "_cs_len"}, r.csw, rd ? SC + 1 : SC + 2);
            check({tag, "_oe_len"}, r.oe,  rd ? 0 : SC + 2);
        end
    endtask

    function automatic logic [7:0] eoi_model(input bit spec, input logic [2:0] lvl);
        return spec ? 8'(8'h60 + lvl) : 8'h20;
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        start_init = 0; INT = 0; vector_ready = 0; eoi_req = 0; eoi_specific = 0; eoi_level = 0;
`ifdef PIC_STATUS_READ_EN
        rd_req = 0; rd_sel = 0;
`endif
        #2;
        check("rst_cs", 32'(chip_select), 1);
        check("rst_re", 32'(read_enable), 1);
        check("rst_we", 32'(write_enable), 1);
        check("rst_inta", 32'(INTA), 1);
        check("rst_a0", 32'(A0), 0);
        check("rst_dout", 32'(data_out), 0);
        check("rst_oe", 32'(data_oe), 0);
        check("rst_vec", 32'(vector), 0);
        check("rst_vv", 32'(vector_valid), 0);
        check("rst_ack", 32'(eoi_ack), 0);
        check("rst_done", 32'(init_done), 0);
        check("rst_busy", 32'(busy), 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        bq.delete();
        pq.delete();
    endtask

    task automatic do_init();
        int cyc;
        @(negedge clock);
        start_init = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start_init = 1'b0;
        cyc = 0;
        while (!init_done && cyc < 100) begin
            @(posedge clock);
            cyc++;
            @(negedge clock);
            if (cyc == 10) check("init_busy", 32'(busy), 1);
        end
        check("init_cycles", cyc, 20);
        expect_bus("icw1", 0, 0, 8'h1F);
        expect_bus("icw2", 0, 1, 8'hA8);
        expect_bus("icw4", 0, 1, 8'h01);
        expect_bus("ocw1", 0, 1, 8'h00);
        check("init_extra", bq.size(), 0);
    endtask

    task automatic run_eoi(input bit spec, input logic [2:0] lvl);
        int n;
        @(negedge clock);
        eoi_req = 1'b1; eoi_specific = spec; eoi_level = lvl;
        n = 0;
        while (eoi_ack !== 1'b1 && n < 60) begin
            @(negedge clock);
            n++;
        end
        check("eoi_wait", 32'(n < 60), 1);
        eoi_req = 1'b0;
        @(negedge clock);
        check("eoi_ack_pulse", 32'(eoi_ack), 0);
        check("eoi_ready", 32'(busy), 0);
        expect_bus("eoi", 0, 0, eoi_model(spec, lvl));
        check("eoi_no_inta", pq.size(), 0);
    endtask

    task automatic run_irq(input logic [7:0] vec, input int hold, input int drop_at,
                           input bit with_eoi, input bit spec, input logic [2:0] lvl, input bit poke);
        int n, pulses, acks, wseq;
        logic prev;
        pulse_t p1, p2;
        @(negedge clock);
        pic_vec = vec;
        INT = 1'b1;
        if (with_eoi) begin
            eoi_req = 1'b1; eoi_specific = spec; eoi_level = lvl;
        end
        n = 0; pulses = 0; acks = 0; prev = 1'b1;
        while (vector_valid !== 1'b1 && n < 80) begin
            @(negedge clock);
            n++;
            if (eoi_ack === 1'b1) begin acks++; eoi_req = 1'b0; end
            if (INTA === 1'b0 && prev === 1'b1) begin
                pulses++;
                if (pulses == drop_at) INT = 1'b0;
            end
            prev = INTA;
        end
        INT = 1'b0;
        check("irq_wait", 32'(n < 80), 1);
        check("irq_vec", 32'(vector), 32'(vec));
        for (int i = 0; i < hold; i++) begin
            check("hold_vv", 32'(vector_valid), 1);
            check("hold_vec", 32'(vector), 32'(vec));
            if (poke && i == 0) start_init = 1'b1;
            @(negedge clock);
            start_init = 1'b0;
        end
        check("hold_vv_end", 32'(vector_valid), 1);
        vector_ready = 1'b1;
        @(negedge clock);
        vector_ready = 1'b0;
        check("vv_clear", 32'(vector_valid), 0);
        check("irq_ready", 32'(busy), 0);
        check("irq_init_kept", 32'(init_done), 1);
        wseq = -1;
        if (with_eoi) begin
            check("irq_eoi_acks", acks, 1);
            if (bq.size() != 0) wseq = bq[0].seq;
            expect_bus("irq_eoi", 0, 0, eoi_model(spec, lvl));
        end
        check("irq_no_bus", bq.size(), 0);
        check("irq_pulses", pq.size(), 2);
        if (pq.size() >= 2) begin
            p1 = pq.pop_front();
            p2 = pq.pop_front();
            check("inta_w1", p1.w, SC);
            check("inta_gap", p2.gap, 1);
            check("inta_w2", p2.w, SC);
            if (with_eoi) check("eoi_before_inta", 32'(wseq >= 0 && wseq < p1.seq), 1);
        end
        pq.delete();
    endtask

    task automatic reset_mid_ack();
        int n, pulses;
        logic prev;
        @(negedge clock);
        pic_vec = 8'h5A;
        INT = 1'b1;
        n = 0; pulses = 0; prev = 1'b1;
        while (pulses < 2 && n < 80) begin
            @(negedge clock);
            n++;
            if (INTA === 1'b0 && prev === 1'b1) pulses++;
            prev = INTA;
        end
        check("ack2_reached", pulses, 2);
        #2 reset_n = 1'b0;
        #1;
        check("mid_inta", 32'(INTA), 1);
        check("mid_cs", 32'(chip_select), 1);
        check("mid_vv", 32'(vector_valid), 0);
        check("mid_done", 32'(init_done), 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        bq.delete();
        pq.delete();
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            check("int_ignored", 32'(INTA), 1);
            check("idle_busy", 32'(busy), 0);
        end
        INT = 1'b0;
        check("idle_no_bus", bq.size(), 0);
    endtask

`ifdef PIC_STATUS_READ_EN
    task automatic run_rd(input logic [1:0] sel);
        int n;
        logic [7:0] exp, got;
        pic_irr = 8'($urandom); pic_isr = 8'($urandom); pic_imr = 8'($urandom);
        exp = (sel == 2'd0) ? pic_irr : (sel == 2'd1) ? pic_isr : pic_imr;
        @(negedge clock);
        rd_req = 1'b1; rd_sel = sel;
        n = 0;
        while (rd_valid !== 1'b1 && n < 60) begin
            @(negedge clock);
            n++;
        end
        got = rd_data;
        rd_req = 1'b0;
        check("rd_wait", 32'(n < 60), 1);
        check("rd_data", 32'(got), 32'(exp));
        @(negedge clock);
        check("rd_pulse", 32'(rd_valid), 0);
        if (sel < 2'd2) begin
            expect_bus("rd_ocw3", 0, 0, (sel == 2'd1) ? 8'h0B : 8'h0A);
            expect_bus("rd_read", 1, 0, exp);
        end else begin
            expect_bus("rd_imr", 1, 1, exp);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        do_reset();
        do_init();
        run_irq(8'hAB, 5, 1, 0, 0, 3'd0, 0);
        run_eoi(1, 3'd3);
        run_eoi(0, 3'd6);
        run_irq(8'h3C, 2, 2, 1, 1, 3'd5, 0);
        run_irq(8'h77, 3, 1, 0, 0, 3'd0, 1);
        for (int k = 0; k < 16; k++) begin
            op = int'($urandom_range(0, 2));
            case (op)
                0: run_eoi(1'($urandom), 3'($urandom));
                1: run_irq(8'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(1, 2)),
                           0, 0, 3'd0, 1'($urandom));
                default: run_irq(8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(1, 2)),
                                 1, 1'($urandom), 3'($urandom), 0);
            endcase
        end
`ifdef PIC_STATUS_READ_EN
        run_rd(2'd1);
        run_rd(2'd0);
        run_rd(2'd2);
        run_rd(2'd3);
`endif
        reset_mid_ack();
        do_init();
        run_irq(8'hC3, 1, 2, 0, 0, 3'd0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
